// File: rtl/trackball_decoder.sv
// Trackball step receiver: deglitches h/v step lines, counts direction-qualified steps
// per axis and presents a snapshot byte to the CPU. Define TB_DELTA_EN for read-clearing saturating deltas.
module trackball_decoder #(
    parameter int CNT_W = 4,
    parameter int FILT  = 3
) (
    input  logic       clk_10M,
    input  logic       reset_n,
    input  logic       ce_5M,
    input  logic       h_clk,
    input  logic       h_dir,
    input  logic       v_clk,
    input  logic       v_dir,
    input  logic       flip,
    input  logic       rd_strobe,
    output logic [7:0] rd_data,
    output logic       step_h,
    output logic       step_v
);

    // Index 0 is the horizontal axis, index 1 the vertical axis.
    logic [1:0]       line_in;
    logic [1:0]       dir_up;
    logic [1:0]       lvl_q, lvl_d;
    logic [3:0]       agr_q [2];
    logic [3:0]       agr_d [2];
    logic [1:0]       rise;
    logic [1:0]       step_q;
    logic [CNT_W-1:0] cnt_q  [2];
    logic [CNT_W-1:0] cnt_d  [2];
    logic [CNT_W-1:0] snap_q [2];
    logic [CNT_W-1:0] snap_d [2];

    assign line_in = {v_clk, h_clk};
    assign dir_up  = {v_dir, h_dir} ^ {flip, flip};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lvl_d[i] = lvl_q[i];
            agr_d[i] = agr_q[i];
            if (ce_5M) begin
                if (line_in[i] != lvl_q[i]) begin
                    if (agr_q[i] + 4'd1 == 4'(FILT)) begin
                        lvl_d[i] = line_in[i];
                        agr_d[i] = 4'd0;
                    end else begin
                        agr_d[i] = agr_q[i] + 4'd1;
                    end
                end else begin
                    agr_d[i] = 4'd0;
                end
            end
        end
    end

    // A step is taken in the cycle the filter accepts a rising level, so the
    // counter and the registered step pulse change on the same clock edge.
    assign rise = lvl_d & ~lvl_q;

`ifdef TB_DELTA_EN
    localparam logic [CNT_W-1:0] DELTA_MAX = CNT_W'(7);
    localparam logic [CNT_W-1:0] DELTA_MIN = ~CNT_W'(7);
    logic [CNT_W-1:0] base [2];
`endif

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            snap_d[i] = rd_strobe ? cnt_q[i] : snap_q[i];
`ifdef TB_DELTA_EN
            // A read clears the delta; a coincident step restarts it at +/-1.
            base[i]  = rd_strobe ? '0 : cnt_q[i];
            cnt_d[i] = base[i];
            if (rise[i]) begin
                if (dir_up[i]) begin
                    if (base[i] != DELTA_MAX) cnt_d[i] = base[i] + 1'b1;
                end else begin
                    if (base[i] != DELTA_MIN) cnt_d[i] = base[i] - 1'b1;
                end
            end
`else
            cnt_d[i] = cnt_q[i];
            if (rise[i]) begin
                cnt_d[i] = dir_up[i] ? cnt_q[i] + 1'b1 : cnt_q[i] - 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_10M or negedge reset_n) begin
        if (!reset_n) begin
            lvl_q  <= '0;
            step_q <= '0;
            for (int i = 0; i < 2; i++) begin
                agr_q[i]  <= '0;
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            lvl_q  <= lvl_d;
            step_q <= rise;
            for (int i = 0; i < 2; i++) begin
                agr_q[i]  <= agr_d[i];
                cnt_q[i]  <= cnt_d[i];
                snap_q[i] <= snap_d[i];
            end
        end
    end

    assign step_h  = step_q[0];
    assign step_v  = step_q[1];
    assign rd_data = {snap_q[1][3:0], snap_q[0][3:0]};

endmodule

// File: tb/tb_trackball_decoder.sv
// Self-checking bench for trackball_decoder; the model follows TB_DELTA_EN when defined.
module tb_trackball_decoder;

    localparam int FILT = 3;

    logic       clk_10M = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_5M = 1'b0;
    logic       h_clk = 1'b0;
    logic       h_dir = 1'b0;
    logic       v_clk = 1'b0;
    logic       v_dir = 1'b0;
    logic       flip = 1'b0;
    logic       rd_strobe = 1'b0;
    logic [7:0] rd_data;
    logic       step_h;
    logic       step_v;

    int checks = 0;
    int errors = 0;
    int step_h_cnt = 0;
    int step_v_cnt = 0;

    logic [3:0] hm = 4'h0;
    logic [3:0] vm = 4'h0;
    logic [7:0] exp_q[$];

    trackball_decoder #(.CNT_W(4), .FILT(FILT)) dut (
        .clk_10M  (clk_10M),
        .reset_n  (reset_n),
        .ce_5M    (ce_5M),
        .h_clk    (h_clk),
        .h_dir    (h_dir),
        .v_clk    (v_clk),
        .v_dir    (v_dir),
        .flip     (flip),
        .rd_strobe(rd_strobe),
        .rd_data  (rd_data),
        .step_h   (step_h),
        .step_v   (step_v)
    );

    // clock / reset
    always #50 clk_10M = ~clk_10M;

    initial begin
        #5ms;
        $display("FAIL watchdog: run did not complete (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    always @(negedge clk_10M) begin
        if (step_h) step_h_cnt++;
        if (step_v) step_v_cnt++;
    end

    // model of one accepted step
    function automatic logic [3:0] step_model(input logic [3:0] cur, input logic up);
`ifdef TB_DELTA_EN
        if (up) return (cur == 4'h7) ? cur : cur + 4'd1;
        else    return (cur == 4'h8) ? cur : cur - 4'd1;
`else
        return up ? cur + 4'd1 : cur - 4'd1;
`endif
    endfunction

    // drivers
    task automatic ce_sample();
        ce_5M = 1'b1;
        @(posedge clk_10M); #1;
        ce_5M = 1'b0;
        @(posedge clk_10M); #1;
    endtask

    task automatic pulse(input logic do_h, input logic do_v, input logic hd, input logic vd,
                         input int n_high);
        h_dir = hd; v_dir = vd;
        h_clk = do_h; v_clk = do_v;
        repeat (n_high) ce_sample();
        h_clk = 1'b0; v_clk = 1'b0;
        repeat (4) ce_sample();
        if (n_high >= FILT) begin
            if (do_h) hm = step_model(hm, hd ^ flip);
            if (do_v) vm = step_model(vm, vd ^ flip);
        end
    endtask

    task automatic do_read(input string name);
        logic [7:0] exp_v;
        logic [7:0] got;
        exp_q.push_back({vm, hm});
`ifdef TB_DELTA_EN
        hm = 4'h0; vm = 4'h0;
`endif
        rd_strobe = 1'b1;
        @(posedge clk_10M); #1;
        rd_strobe = 1'b0;
        @(negedge clk_10M);
        got = rd_data;
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: rd_data got %h expected %h", name, got, exp_v);
        end
        @(negedge clk_10M);
        checks++;
        if (rd_data !== exp_v) begin
            errors++;
            $display("FAIL %s_hold: rd_data got %h expected %h", name, rd_data, exp_v);
        end
        @(posedge clk_10M); #1;
    endtask

    task automatic check_steps(input string name, input int exp_h, input int exp_v);
        checks++;
        if (step_h_cnt !== exp_h || step_v_cnt !== exp_v) begin
            errors++;
            $display("FAIL %s: steps h/v got %0d/%0d expected %0d/%0d",
                     name, step_h_cnt, step_v_cnt, exp_h, exp_v);
        end
        step_h_cnt = 0; step_v_cnt = 0;
    endtask

    // tests
    task automatic test_reset();
        for (int i = 0; i < 16; i++) begin
            {ce_5M, h_clk, h_dir, v_clk, v_dir, flip, rd_strobe} = 7'($urandom_range(0, 127));
            @(negedge clk_10M);
            checks++;
            if (rd_data !== 8'h00 || step_h !== 1'b0 || step_v !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: rd_data/step_h/step_v got %h/%b/%b expected 00/0/0",
                         rd_data, step_h, step_v);
            end
        end
        {ce_5M, h_clk, h_dir, v_clk, v_dir, flip, rd_strobe} = '0;
        @(posedge clk_10M); #1;
        reset_n = 1'b1;
        @(posedge clk_10M); #1;
        step_h_cnt = 0; step_v_cnt = 0;
        do_read("reset_read");
    endtask

    task automatic test_wrap_flip();
        flip = 1'b1;
        repeat (3) pulse(1'b0, 1'b1, 1'b0, 1'b1, 4);
        check_steps("wrap_steps", 0, 3);
        do_read("wrap_flip_neg");
        flip = 1'b0;
        repeat (3) pulse(1'b0, 1'b1, 1'b0, 1'b1, 4);
        check_steps("wrap_steps_pos", 0, 3);
        do_read("wrap_flip_pos");
    endtask

    task automatic test_counting();
        repeat (5) pulse(1'b1, 1'b0, 1'b1, 1'b0, 4);
        check_steps("count_steps", 5, 0);
        do_read("count_read");
    endtask

    task automatic test_glitch();
        pulse(1'b1, 1'b0, 1'b1, 1'b0, 2);
        check_steps("glitch_steps", 0, 0);
        do_read("glitch_read");
        pulse(1'b1, 1'b0, 1'b1, 1'b0, 3);
        check_steps("glitch_accept_steps", 1, 0);
        do_read("glitch_accept_read");
    endtask

    // h step accepted in the same cycle as the read strobe
    task automatic test_collision(input string name, input logic hd);
        logic [7:0] exp_v;
        h_dir = hd; h_clk = 1'b1;
        repeat (FILT - 1) ce_sample();
        exp_q.push_back({vm, hm});
`ifdef TB_DELTA_EN
        hm = 4'h0; vm = 4'h0;
`endif
        hm = step_model(hm, hd ^ flip);
        ce_5M = 1'b1; rd_strobe = 1'b1;
        @(posedge clk_10M); #1;
        ce_5M = 1'b0; rd_strobe = 1'b0;
        @(negedge clk_10M);
        exp_v = exp_q.pop_front();
        checks++;
        if (rd_data !== exp_v) begin
            errors++;
            $display("FAIL %s: rd_data got %h expected %h", name, rd_data, exp_v);
        end
        @(posedge clk_10M); #1;
        ce_sample();
        h_clk = 1'b0;
        repeat (4) ce_sample();
        check_steps({name, "_steps"}, 1, 0);
        do_read({name, "_next"});
    endtask

    task automatic test_simultaneous();
        int n;
        n = $urandom_range(4, 8);
        for (int k = 0; k < n; k++) begin
            flip = 1'($urandom_range(0, 1));
            pulse(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4);
        end
        flip = 1'b0;
        check_steps("simul_steps", n, n);
        do_read("simul_read");
    endtask

    task automatic test_saturation();
        repeat (10) pulse(1'b1, 1'b0, 1'b1, 1'b0, 4);
        check_steps("sat_steps", 10, 0);
        do_read("sat_read");
        do_read("sat_reread");
        test_collision("sat_collision", 1'b0);
    endtask

    task automatic test_midop_reset();
        h_dir = 1'b1; h_clk = 1'b1;
        repeat (2) ce_sample();
        reset_n = 1'b0;
        #10;
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL midop_reset: rd_data got %h expected 00", rd_data);
        end
        @(posedge clk_10M); #1;
        reset_n = 1'b1;
        hm = 4'h0; vm = 4'h0;
        step_h_cnt = 0; step_v_cnt = 0;
        ce_sample();
        h_clk = 1'b0;
        repeat (4) ce_sample();
        check_steps("midop_steps", 0, 0);
        do_read("midop_read");
    endtask

    initial begin
        test_reset();
        test_wrap_flip();
        test_counting();
        test_glitch();
        test_collision("collision", 1'b1);
        test_simultaneous();
        test_saturation();
        test_midop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trackball_decoder.md
Name: trackball_decoder

Overview:
- Core-side receiver for the trackball step interface: h_clk/h_dir and v_clk/v_dir, produced by the trackball emulation from mouse or joystick input.
- Deglitches each step line, detects its rising edges and accumulates per-axis up/down position counters, like the arcade board's trackball counter chips.
- Presents a CPU-readable byte: horizontal count in bits [3:0], vertical count in bits [7:4].
- Sits inside the core between the trackball block and the CPU input mux, on clk_10M.

Parameters:
CNT_W, 4, width of each axis counter; rd_data carries the low 4 bits of each.
FILT, 3, number of consecutive ce_5M samples at a new level before a step line is accepted (1..15).

Ports:
clk_10M  in  1  core clock
reset_n  in  1  asynchronous, active-low reset
ce_5M  in  1  sample enable; filters advance only when high
h_clk  in  1  horizontal step line; each accepted rising edge is one step
h_dir  in  1  horizontal direction: 1 = +1, 0 = -1
v_clk  in  1  vertical step line
v_dir  in  1  vertical direction: 1 = +1, 0 = -1
flip  in  1  cocktail flip; 1 inverts both directions
rd_strobe  in  1  one-cycle CPU read of the trackball port
rd_data  out  8  {v_snap[3:0], h_snap[3:0]}
step_h  out  1  one-cycle pulse on each accepted horizontal step
step_v  out  1  one-cycle pulse on each accepted vertical step

Behaviour:
- Reset (asynchronous, reset_n=0): filters, accepted levels and counters all go to 0; rd_data=8'h00, step_h=0, step_v=0. Reset takes effect mid-operation and discards pending filter counts.
- Filter, one per step line:
  - Per-line state: accepted level L and a 4-bit agreement counter.
  - On a ce_5M cycle where the input differs from L, the counter increments; when it reaches FILT, L takes the input and the counter clears.
  - On a ce_5M cycle where the input equals L, the counter clears.
  - When ce_5M=0, state holds.
- Edge detect: an accepted 0->1 transition of L produces step_x=1 for exactly one clk_10M cycle. Steps are registered: step_x is asserted in the cycle after L changes.
- Direction:
  - The direction is the dir input sampled in the same cycle L changes.
  - dir XOR flip = 1 adds +1 to the axis counter; otherwise -1.
  - Counters are CNT_W bits, modulo 2^CNT_W: 0-1 gives all-ones, max+1 gives 0.
- Counter update happens in the same cycle step_x asserts.
- Read:
  - On rd_strobe, h_snap/v_snap load the live counters' pre-update value for that cycle.
  - rd_data is valid in the cycle after rd_strobe and holds until the next strobe.
  - A step coinciding with rd_strobe still updates the live counter and appears in the next read.
- Simultaneous h and v steps are independent and both counted.
- h_dir/v_dir are not filtered; they must be stable when the clk line is accepted.
- Inputs are synchronous to clk_10M; no synchronizers are required.

Optional Feature:
Macro TB_DELTA_EN.
- Defined:
  - Counters become signed saturating deltas, clamped to -8..+7 in rd_data nibbles.
  - rd_strobe snapshots the deltas and clears them to 0.
  - A step in the same cycle as rd_strobe is not lost: the delta restarts at +1 or -1.
- Not defined: free-running wrapping counters exactly as described in Behaviour.

Test Plan:
- Reset: hold reset_n=0, toggle all inputs -> rd_data=8'h00, no step pulses; release, rd_strobe -> rd_data=8'h00.
- Counting: FILT=3, ce_5M every other cycle, 5 clean h_clk pulses (high and low 4 ce each) with h_dir=1, then rd_strobe -> rd_data=8'h05, exactly 5 step_h pulses.
- Wrap and flip: 3 v_clk pulses with v_dir=1 and flip=1 -> rd_data=8'hD0; then 3 pulses with flip=0 -> 8'h00.
- Glitch rejection: h_clk high for 2 ce samples then low -> no step_h, count unchanged; high for 3 samples -> one step.
- Collision: h step accepted in the same cycle as rd_strobe, starting from count 2 -> rd_data low nibble=2; next read=3.
- TB_DELTA_EN build: 10 +steps then read -> low nibble 4'h7, live delta cleared; read again -> 4'h0; read with a coincident -step -> 0, next read 4'hF.
